// File: rtl/cpu_ctrl_pkg.sv
// Shared types and encodings for the multi-cycle MIPS-subset controller.
package cpu_ctrl_pkg;

   localparam int unsigned OP_W    = 6;
   localparam int unsigned STATE_W = 3;

   typedef enum logic [STATE_W-1:0] {
      ST_FETCH  = 3'd0,
      ST_DECODE = 3'd1,
      ST_EXEC   = 3'd2,
      ST_MEM    = 3'd3,
      ST_WB     = 3'd4
   } state_e;

   localparam logic [OP_W-1:0] OP_RTYPE = 6'h00;
   localparam logic [OP_W-1:0] OP_J     = 6'h02;
   localparam logic [OP_W-1:0] OP_JAL   = 6'h03;
   localparam logic [OP_W-1:0] OP_BEQ   = 6'h04;
   localparam logic [OP_W-1:0] OP_BNE   = 6'h05;
   localparam logic [OP_W-1:0] OP_XORI  = 6'h0E;
   localparam logic [OP_W-1:0] OP_LW    = 6'h23;
   localparam logic [OP_W-1:0] OP_SW    = 6'h2B;

   localparam logic [OP_W-1:0] FN_JR    = 6'h08;
   localparam logic [OP_W-1:0] FN_ADD   = 6'h20;
   localparam logic [OP_W-1:0] FN_SUB   = 6'h22;
   localparam logic [OP_W-1:0] FN_SLT   = 6'h2A;

   typedef enum logic [1:0] {
      ALU_ADD = 2'd0,
      ALU_SUB = 2'd1,
      ALU_SLT = 2'd2,
      ALU_XOR = 2'd3
   } alu_op_e;

   typedef enum logic [1:0] {
      DST_RT = 2'd0,
      DST_RD = 2'd1,
      DST_RA = 2'd2
   } reg_dst_e;

   typedef enum logic [3:0] {
      IC_ALU_R,
      IC_JR,
      IC_LW,
      IC_SW,
      IC_BRANCH,
      IC_J,
      IC_JAL,
      IC_XORI,
      IC_ILLEGAL
   } iclass_e;

endpackage

// File: rtl/mc_control_if.sv
// Controller <-> IFU/datapath signal bundle.
interface mc_control_if;
   logic       run;
   logic [5:0] opcode;
   logic [5:0] funct;
   logic       mem_ready;
   logic       pc_write;
   logic       ir_write;
   logic       jump;
   logic       jump_reg;
   logic       branch;
   logic       inv_zero;
   logic       reg_write;
   logic [1:0] reg_dst;
   logic       mem_to_reg;
   logic       alu_src;
   logic [1:0] alu_op;
   logic       mem_read;
   logic       mem_write;
   logic       illegal;
   logic       mem_timeout;
   logic [2:0] state;

   modport master (
      input  run, opcode, funct, mem_ready,
      output pc_write, ir_write, jump, jump_reg, branch, inv_zero,
             reg_write, reg_dst, mem_to_reg, alu_src, alu_op,
             mem_read, mem_write, illegal, mem_timeout, state
   );

   modport slave (
      output run, opcode, funct, mem_ready,
      input  pc_write, ir_write, jump, jump_reg, branch, inv_zero,
             reg_write, reg_dst, mem_to_reg, alu_src, alu_op,
             mem_read, mem_write, illegal, mem_timeout, state
   );
endinterface

// File: rtl/mc_decode.sv
// Combinational opcode/funct classifier.
module mc_decode
   import cpu_ctrl_pkg::*;
(
   input  logic [OP_W-1:0] opcode,
   input  logic [OP_W-1:0] funct,
   output iclass_e         iclass_c,
   output alu_op_e         r_alu_op_c,
   output logic            illegal_c
);

   // Map IR fields to an instruction class; anything unmatched is illegal.
   always_comb begin
      iclass_c   = IC_ILLEGAL;
      r_alu_op_c = ALU_ADD;
      case (opcode)
         OP_RTYPE: begin
            case (funct)
               FN_ADD: begin iclass_c = IC_ALU_R; r_alu_op_c = ALU_ADD; end
               FN_SUB: begin iclass_c = IC_ALU_R; r_alu_op_c = ALU_SUB; end
               FN_SLT: begin iclass_c = IC_ALU_R; r_alu_op_c = ALU_SLT; end
               FN_JR:  iclass_c = IC_JR;
               default: iclass_c = IC_ILLEGAL;
            endcase
         end
         OP_J:    iclass_c = IC_J;
         OP_JAL:  iclass_c = IC_JAL;
         OP_BEQ:  iclass_c = IC_BRANCH;
         OP_BNE:  iclass_c = IC_BRANCH;
         OP_XORI: iclass_c = IC_XORI;
         OP_LW:   iclass_c = IC_LW;
         OP_SW:   iclass_c = IC_SW;
         default: iclass_c = IC_ILLEGAL;
      endcase
   end

   assign illegal_c = (iclass_c == IC_ILLEGAL);

endmodule

// File: rtl/mc_control.sv
// Multi-cycle control FSM: sequences IFU selects, datapath enables and PC write.
// Outputs are decoded from the current state and IR fields; they are forced
// low while rst_n is asserted so an abandoned instruction never writes.
module mc_control
   import cpu_ctrl_pkg::*;
#(
   parameter int unsigned MEM_WAIT_MAX = 15,
   parameter int unsigned CNT_W        = 4
)(
   input  logic         clk,
   input  logic         rst_n,
   mc_control_if.master bus
);

   state_e           state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   iclass_e          iclass;
   alu_op_e          r_alu_op;
   logic             illegal_c;
   logic             wait_done_c;

   mc_decode u_decode (
      .opcode     (bus.opcode),
      .funct      (bus.funct),
      .iclass_c   (iclass),
      .r_alu_op_c (r_alu_op),
      .illegal_c  (illegal_c)
   );

   // Last permitted MEM cycle: the counter holds the number of cycles already spent there.
   assign wait_done_c = (cnt_q == CNT_W'(MEM_WAIT_MAX - 1));
   assign bus.state   = STATE_W'(state_q);

   // State and wait-counter registers.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q <= ST_FETCH;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
      end
   end

   // Next-state and output decode.
   always_comb begin
      state_d         = state_q;
      cnt_d           = '0;
      bus.pc_write    = 1'b0;
      bus.ir_write    = 1'b0;
      bus.jump        = 1'b0;
      bus.jump_reg    = 1'b0;
      bus.branch      = 1'b0;
      bus.inv_zero    = 1'b0;
      bus.reg_write   = 1'b0;
      bus.reg_dst     = DST_RT;
      bus.mem_to_reg  = 1'b0;
      bus.alu_src     = 1'b0;
      bus.alu_op      = ALU_ADD;
      bus.mem_read    = 1'b0;
      bus.mem_write   = 1'b0;
      bus.illegal     = 1'b0;
      bus.mem_timeout = 1'b0;
      if (rst_n) begin
         case (state_q)
            ST_FETCH: begin
               bus.ir_write = bus.run;
               if (bus.run) state_d = ST_DECODE;
            end
            ST_DECODE: begin
               state_d = ST_EXEC;
               if (illegal_c) begin
                  bus.illegal  = 1'b1;
                  bus.pc_write = 1'b1;
                  state_d      = ST_FETCH;
               end else if (iclass == IC_J || iclass == IC_JAL) begin
                  bus.jump     = 1'b1;
                  bus.pc_write = 1'b1;
                  state_d      = ST_FETCH;
                  if (iclass == IC_JAL) begin
                     bus.reg_write = 1'b1;
                     bus.reg_dst   = DST_RA;
                  end
               end
            end
            ST_EXEC: begin
               state_d = ST_FETCH;
               case (iclass)
                  IC_ALU_R: begin
                     bus.alu_op = r_alu_op;
                     state_d    = ST_WB;
                  end
                  IC_XORI: begin
                     bus.alu_src = 1'b1;
                     bus.alu_op  = ALU_XOR;
                     state_d     = ST_WB;
                  end
                  IC_LW, IC_SW: begin
                     bus.alu_src = 1'b1;
                     state_d     = ST_MEM;
                  end
                  IC_BRANCH: begin
                     bus.alu_op   = ALU_SUB;
                     bus.branch   = 1'b1;
                     bus.inv_zero = (bus.opcode == OP_BNE);
                     bus.pc_write = 1'b1;
                  end
                  IC_JR: begin
                     bus.jump_reg = 1'b1;
                     bus.pc_write = 1'b1;
                  end
                  default: state_d = ST_FETCH;
               endcase
            end
            ST_MEM: begin
               bus.mem_read  = (iclass == IC_LW);
               bus.mem_write = (iclass == IC_SW);
               if (bus.mem_ready) begin
                  bus.pc_write = (iclass == IC_SW);
                  state_d      = (iclass == IC_LW) ? ST_WB : ST_FETCH;
               end else if (wait_done_c) begin
                  bus.mem_timeout = 1'b1;
                  bus.pc_write    = 1'b1;
                  state_d         = ST_FETCH;
               end else begin
                  cnt_d = cnt_q + CNT_W'(1);
               end
            end
            ST_WB: begin
               bus.pc_write   = 1'b1;
               bus.reg_write  = 1'b1;
               bus.reg_dst    = (iclass == IC_ALU_R) ? DST_RD : DST_RT;
               bus.mem_to_reg = (iclass == IC_LW);
               state_d        = ST_FETCH;
            end
            default: state_d = ST_FETCH;
         endcase
      end
   end

endmodule

// File: tb/tb_mc_control.sv
// Scoreboard bench for mc_control: stimulus queues expected per-cycle outputs,
// a monitor pops and compares them each cycle.
module tb_mc_control;
   import cpu_ctrl_pkg::*;

   // Expected control word, MSB first: pc_write ir_write jump jump_reg branch
   // inv_zero reg_write reg_dst[1:0] mem_to_reg alu_src alu_op[1:0]
   // mem_read mem_write illegal mem_timeout
   localparam logic [16:0] PCW  = 17'h10000;
   localparam logic [16:0] IRW  = 17'h08000;
   localparam logic [16:0] JMP  = 17'h04000;
   localparam logic [16:0] JR   = 17'h02000;
   localparam logic [16:0] BR   = 17'h01000;
   localparam logic [16:0] INV  = 17'h00800;
   localparam logic [16:0] RW   = 17'h00400;
   localparam logic [16:0] DRA  = 17'h00200;
   localparam logic [16:0] DRD  = 17'h00100;
   localparam logic [16:0] M2R  = 17'h00080;
   localparam logic [16:0] ASRC = 17'h00040;
   localparam logic [16:0] ASLT = 17'h00020;
   localparam logic [16:0] ASUB = 17'h00010;
   localparam logic [16:0] AXOR = 17'h00030;
   localparam logic [16:0] MRD  = 17'h00008;
   localparam logic [16:0] MWR  = 17'h00004;
   localparam logic [16:0] ILL  = 17'h00002;
   localparam logic [16:0] TMO  = 17'h00001;
   localparam logic [16:0] NONE = 17'h00000;

   logic clk = 1'b0;
   logic rst_n;
   always #5 clk = ~clk;

   mc_control_if bus ();

   mc_control #(.MEM_WAIT_MAX(15), .CNT_W(4)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   logic [19:0] exp_q[$];
   string       lbl_q[$];
   int          total = 0;
   int          bad   = 0;

   logic [5:0]  cur_op   = 6'h00;
   logic [5:0]  cur_fn   = 6'h00;
   logic        cur_run  = 1'b1;
   logic        cur_rstn = 1'b1;

   // Drive one cycle of inputs and queue the outputs expected in that cycle.
   task automatic cyc(input string lbl, input logic [2:0] st, input logic [16:0] fl,
                      input logic rdy = 1'b0);
      @(posedge clk);
      #1;
      rst_n         = cur_rstn;
      bus.run       = cur_run;
      bus.opcode    = cur_op;
      bus.funct     = cur_fn;
      bus.mem_ready = rdy;
      exp_q.push_back({st, fl});
      lbl_q.push_back(lbl);
   endtask

   task automatic instr(input logic [5:0] op, input logic [5:0] fn);
      cur_op = op;
      cur_fn = fn;
   endtask

   // Monitor: compare DUT outputs against the head of the scoreboard each cycle.
   initial begin
      logic [19:0] got;
      logic [19:0] want;
      string       lbl;
      forever begin
         @(negedge clk);
         if (exp_q.size() > 0) begin
            want = exp_q.pop_front();
            lbl  = lbl_q.pop_front();
            got  = {bus.state, bus.pc_write, bus.ir_write, bus.jump, bus.jump_reg,
                    bus.branch, bus.inv_zero, bus.reg_write, bus.reg_dst,
                    bus.mem_to_reg, bus.alu_src, bus.alu_op, bus.mem_read,
                    bus.mem_write, bus.illegal, bus.mem_timeout};
            total++;
            if (got !== want) begin
               bad++;
               $display("FAIL %s: got state=%0d ctl=%05h, want state=%0d ctl=%05h",
                        lbl, got[19:17], got[16:0], want[19:17], want[16:0]);
            end
         end
      end
   end

   initial begin
      rst_n         = 1'b0;
      bus.run       = 1'b1;
      bus.opcode    = 6'h00;
      bus.funct     = 6'h00;
      bus.mem_ready = 1'b0;
      @(posedge clk);

      // Reset held, then released with run=1
      cur_rstn = 1'b0;
      cyc("rst_hold", 3'd0, NONE);
      cur_rstn = 1'b1;
      cyc("rst_rel_fetch", 3'd0, IRW);

      // add
      instr(OP_RTYPE, FN_ADD);
      cyc("add_d", 3'd1, NONE);
      cyc("add_e", 3'd2, NONE);
      cyc("add_w", 3'd4, PCW | RW | DRD);

      // lw, ready on third MEM cycle
      instr(OP_LW, 6'h00);
      cyc("lw_f", 3'd0, IRW);
      cyc("lw_d", 3'd1, NONE);
      cyc("lw_e", 3'd2, ASRC);
      cyc("lw_m1", 3'd3, MRD);
      cyc("lw_m2", 3'd3, MRD);
      cyc("lw_m3", 3'd3, MRD, 1'b1);
      cyc("lw_w", 3'd4, PCW | RW | M2R);

      // bne / beq
      instr(OP_BNE, 6'h00);
      cyc("bne_f", 3'd0, IRW);
      cyc("bne_d", 3'd1, NONE);
      cyc("bne_e", 3'd2, PCW | BR | INV | ASUB);
      instr(OP_BEQ, 6'h00);
      cyc("beq_f", 3'd0, IRW);
      cyc("beq_d", 3'd1, NONE);
      cyc("beq_e", 3'd2, PCW | BR | ASUB);

      // j and jal finish in DECODE
      instr(OP_J, 6'h00);
      cyc("j_f", 3'd0, IRW);
      cyc("j_d", 3'd1, PCW | JMP);
      instr(OP_JAL, 6'h00);
      cyc("jal_f", 3'd0, IRW);
      cyc("jal_d", 3'd1, PCW | JMP | RW | DRA);

      // jr
      instr(OP_RTYPE, FN_JR);
      cyc("jr_f", 3'd0, IRW);
      cyc("jr_d", 3'd1, NONE);
      cyc("jr_e", 3'd2, PCW | JR);

      // slt and sub
      instr(OP_RTYPE, FN_SLT);
      cyc("slt_f", 3'd0, IRW);
      cyc("slt_d", 3'd1, NONE);
      cyc("slt_e", 3'd2, ASLT);
      cyc("slt_w", 3'd4, PCW | RW | DRD);
      instr(OP_RTYPE, FN_SUB);
      cyc("sub_f", 3'd0, IRW);
      cyc("sub_d", 3'd1, NONE);
      cyc("sub_e", 3'd2, ASUB);
      cyc("sub_w", 3'd4, PCW | RW | DRD);

      // xori
      instr(OP_XORI, 6'h00);
      cyc("xori_f", 3'd0, IRW);
      cyc("xori_d", 3'd1, NONE);
      cyc("xori_e", 3'd2, ASRC | AXOR);
      cyc("xori_w", 3'd4, PCW | RW);

      // sw with immediate ready
      instr(OP_SW, 6'h00);
      cyc("sw_f", 3'd0, IRW);
      cyc("sw_d", 3'd1, NONE);
      cyc("sw_e", 3'd2, ASRC);
      cyc("sw_m1", 3'd3, MWR | PCW, 1'b1);

      // sw timeout: 15 MEM cycles, abort on the last
      cyc("swto_f", 3'd0, IRW);
      cyc("swto_d", 3'd1, NONE);
      cyc("swto_e", 3'd2, ASRC);
      for (int i = 0; i < 14; i++) cyc("swto_wait", 3'd3, MWR);
      cyc("swto_abort", 3'd3, MWR | PCW | TMO);

      // sw whose ready lands on the last permitted cycle: completion wins
      cyc("swlate_f", 3'd0, IRW);
      cyc("swlate_d", 3'd1, NONE);
      cyc("swlate_e", 3'd2, ASRC);
      for (int i = 0; i < 14; i++) cyc("swlate_wait", 3'd3, MWR);
      cyc("swlate_done", 3'd3, MWR | PCW, 1'b1);

      // Illegal opcode and illegal R-type funct
      instr(6'h3F, 6'h00);
      cyc("ill_f", 3'd0, IRW);
      cyc("ill_d", 3'd1, PCW | ILL);
      instr(OP_RTYPE, 6'h21);
      cyc("illfn_f", 3'd0, IRW);
      cyc("illfn_d", 3'd1, PCW | ILL);

      // Halt: run low holds FETCH, mem_ready ignored
      cur_run = 1'b0;
      cyc("halt1", 3'd0, NONE, 1'b1);
      cyc("halt2", 3'd0, NONE);
      cur_run = 1'b1;

      // Reset during lw MEM abandons the instruction
      instr(OP_LW, 6'h00);
      cyc("lwr_f", 3'd0, IRW);
      cyc("lwr_d", 3'd1, NONE);
      cyc("lwr_e", 3'd2, ASRC);
      cyc("lwr_m1", 3'd3, MRD);
      cur_rstn = 1'b0;
      cyc("lwr_rst", 3'd3, NONE, 1'b1);
      cur_rstn = 1'b1;
      cyc("lwr_after", 3'd0, IRW);
      cyc("lwr_after_d", 3'd1, NONE);

      @(posedge clk);
      @(negedge clk);
      #1;
      total++;
      if (exp_q.size() != 0) begin
         bad++;
         $display("FAIL scoreboard_drain: got %0d pending, want 0", exp_q.size());
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
